// File: rtl/multi_game_hub_pkg.sv
// Shared types and constants for the multi-game hub: session states,
// banner image indices and the 12-bit pixel type.
package multi_game_hub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REGEN,
    COUNT,
    RUN,
    PAUSED,
    WON,
    LOST
  } state_e;

  localparam int IMG_START = 0;
  localparam int IMG_PAUSE = 1;
  localparam int IMG_WIN   = 2;
  localparam int IMG_LOSE  = 3;

  // One round-timer second at the 25 MHz pixel clock.
  localparam int SECOND_CYCLES = 25_000_000;

  typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/multi_game_hub_if.sv
// Pixel-coordinate bundle between the VGA timing side and the screen slicer.
// The master drives raw VGA coordinates; the slave returns slice-local ones.
interface multi_game_hub_if #(
  parameter int NUM_GAMES     = 2,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600
);
  localparam int SLICE_W = SCREEN_WIDTH / NUM_GAMES;
  localparam int LX_W    = $clog2(SLICE_W);
  localparam int LY_W    = $clog2(SCREEN_HEIGHT);
  localparam int CH_W    = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;

  logic [10:0]     h_coord;
  logic [9:0]      v_coord;
  logic            disp_enbl;
  logic [LX_W-1:0] local_x;
  logic [LY_W-1:0] local_y;
  logic [CH_W-1:0] channel;

  modport master (output h_coord, v_coord, disp_enbl, input local_x, local_y, channel);
  modport slave  (input h_coord, v_coord, disp_enbl, output local_x, local_y, channel);
endinterface

// File: rtl/multi_game_hub_screen_slicer.sv
// Combinational screen slicer: picks the vertical slice under the beam and
// the x offset inside it using a constant compare chain.
module screen_slicer
  import multi_game_hub_pkg::*;
#(
  parameter int NUM_GAMES     = 2,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600
) (
  multi_game_hub_if.slave pix
);
  localparam int SLICE_W = SCREEN_WIDTH / NUM_GAMES;
  localparam int LX_W    = $clog2(SLICE_W);
  localparam int LY_W    = $clog2(SCREEN_HEIGHT);
  localparam int CH_W    = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;

  logic [CH_W-1:0] ch;
  logic [10:0]     base;

  // Beyond the visible width every compare passes, so the last slice wins.
  always_comb begin
    ch   = '0;
    base = '0;
    for (int k = 1; k < NUM_GAMES; k++) begin
      if (pix.h_coord >= 11'(k * SLICE_W)) begin
        ch   = CH_W'(k);
        base = 11'(k * SLICE_W);
      end
    end
  end

  assign pix.channel = ch;
  assign pix.local_x = LX_W'(pix.h_coord - base);
  assign pix.local_y = LY_W'(pix.v_coord);

endmodule

// File: rtl/multi_game_hub.sv
// Multi-game hub top: session FSM, rating, banner select and registered
// pixel compositor. Optional round timer under MULTI_GAME_HUB_ROUND_TIMER_EN.
module multi_game_hub
  import multi_game_hub_pkg::*;
#(
  parameter int NUM_GAMES        = 2,
  parameter int SCREEN_WIDTH     = 800,
  parameter int SCREEN_HEIGHT    = 600,
  parameter int RATING_WIDTH     = 8,
  parameter int NUM_IMAGES       = 4,
  parameter logic [NUM_GAMES-1:0] WIN_MASK = 'b01,
`ifdef MULTI_GAME_HUB_ROUND_TIMER_EN
  parameter int ROUND_CYCLES     = 1_500_000_000,
`endif
  parameter int COUNTDOWN_CYCLES = 25_000_000
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  i_start,
  input  logic                                  i_pause,
  input  logic [NUM_GAMES-1:0]                  i_game_win,
  input  logic [NUM_GAMES-1:0]                  i_game_lose,
  input  logic [NUM_GAMES-1:0]                  i_ready,
  output logic                                  o_regenerate,
  output logic                                  o_game_running,
  output logic                                  o_show_banner,
  output logic [$clog2(NUM_IMAGES)-1:0]         o_image_number,
  output logic [RATING_WIDTH-1:0]               o_rating,
`ifdef MULTI_GAME_HUB_ROUND_TIMER_EN
  output logic [15:0]                           o_time_left,
`endif
  input  logic [10:0]                           i_h_coord,
  input  logic [9:0]                            i_v_coord,
  input  logic                                  i_disp_enbl,
  output logic [$clog2(SCREEN_WIDTH/NUM_GAMES)-1:0] o_local_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0]      o_local_y,
  output logic [((NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1)-1:0] o_channel,
  input  logic [12*NUM_GAMES-1:0]               i_game_rgb,
  input  rgb12_t                                i_banner_rgb,
  output logic [3:0]                            o_red,
  output logic [3:0]                            o_green,
  output logic [3:0]                            o_blue
);
  localparam int IMG_W = $clog2(NUM_IMAGES);
  localparam int CD_W  = $clog2(COUNTDOWN_CYCLES + 1);

  multi_game_hub_if #(
    .NUM_GAMES(NUM_GAMES), .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) pix ();

  assign pix.h_coord   = i_h_coord;
  assign pix.v_coord   = i_v_coord;
  assign pix.disp_enbl = i_disp_enbl;
  assign o_local_x     = pix.local_x;
  assign o_local_y     = pix.local_y;
  assign o_channel     = pix.channel;

  screen_slicer #(
    .NUM_GAMES(NUM_GAMES), .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_slicer (.pix(pix));

  state_e                  state_q, state_d;
  logic                    start_q, start_d;
  logic                    regen_q, regen_d;
  logic [IMG_W-1:0]        img_q, img_d;
  logic [RATING_WIDTH-1:0] rating_q, rating_d;
  logic [CD_W-1:0]         count_q, count_d;
  rgb12_t                  rgb_q, rgb_d;
  logic                    start_edge;
  logic                    timeout;

  assign start_d    = i_start;
  assign start_edge = i_start & ~start_q;

`ifdef MULTI_GAME_HUB_ROUND_TIMER_EN
  localparam int ROUND_SECS = ROUND_CYCLES / SECOND_CYCLES;
  logic [15:0] time_q, time_d;
  logic [24:0] tick_q, tick_d;

  assign timeout     = (state_q == RUN) && (time_q == '0);
  assign o_time_left = time_q;

  always_comb begin
    time_d = time_q;
    tick_d = tick_q;
    if (state_q == COUNT && state_d == RUN) begin
      time_d = 16'(ROUND_SECS);
      tick_d = '0;
    end else if (state_q == RUN) begin
      if (tick_q == 25'(SECOND_CYCLES - 1)) begin
        tick_d = '0;
        if (time_q != '0) time_d = time_q - 16'd1;
      end else begin
        tick_d = tick_q + 25'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      time_q <= '0;
      tick_q <= '0;
    end else begin
      time_q <= time_d;
      tick_q <= tick_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Regenerate/ready handshake: o_regenerate pulses on the REGEN entry
  // cycle; &i_ready is honoured only from the following cycle onward.
  always_comb begin
    state_d  = state_q;
    regen_d  = 1'b0;
    img_d    = img_q;
    rating_d = rating_q;
    count_d  = '0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = REGEN;
          regen_d = 1'b1;
        end
      end
      REGEN: begin
        if (!regen_q && (&i_ready)) state_d = COUNT;
      end
      COUNT: begin
        if (count_q == CD_W'(COUNTDOWN_CYCLES - 1)) state_d = RUN;
        else count_d = count_q + 1'b1;
      end
      RUN: begin
        if ((|i_game_lose) || timeout) begin
          state_d  = LOST;
          img_d    = IMG_W'(IMG_LOSE);
          rating_d = '0;
        end else if (|(i_game_win & WIN_MASK)) begin
          state_d  = WON;
          img_d    = IMG_W'(IMG_WIN);
          rating_d = (&rating_q) ? rating_q : rating_q + 1'b1;
        end else if (i_pause) begin
          state_d = PAUSED;
          img_d   = IMG_W'(IMG_PAUSE);
        end
      end
      PAUSED: begin
        if (!i_pause) state_d = RUN;
      end
      WON, LOST: begin
        if (start_edge) begin
          state_d = REGEN;
          regen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rgb_d = '0;
    if (i_disp_enbl) begin
      rgb_d = o_show_banner ? i_banner_rgb : i_game_rgb[o_channel*12 +: 12];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      regen_q  <= 1'b0;
      img_q    <= IMG_W'(IMG_START);
      rating_q <= '0;
      count_q  <= '0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      regen_q  <= regen_d;
      img_q    <= img_d;
      rating_q <= rating_d;
      count_q  <= count_d;
      rgb_q    <= rgb_d;
    end
  end

  assign o_regenerate   = regen_q;
  assign o_game_running = (state_q == RUN);
  assign o_show_banner  = !(state_q == COUNT || state_q == RUN);
  assign o_image_number = img_q;
  assign o_rating       = rating_q;
  assign o_red          = rgb_q[11:8];
  assign o_green        = rgb_q[7:4];
  assign o_blue         = rgb_q[3:0];

endmodule

// File: tb/tb_multi_game_hub.sv
// Directed testbench for multi_game_hub: a 2-channel hub for the session
// flow and a 4-channel hub for screen slicing and compositing.
module tb_multi_game_hub;
  import multi_game_hub_pkg::*;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 2-channel hub
  logic       start = 0, pause = 0;
  logic [1:0] win = 0, lose = 0, ready = 2'b11;
  logic       regen, running, banner;
  logic [1:0] img;
  logic [7:0] rating;
  logic [3:0] red, green, blue;
  multi_game_hub_if #(.NUM_GAMES(2)) pix2 ();

  multi_game_hub #(.NUM_GAMES(2), .WIN_MASK(2'b01), .COUNTDOWN_CYCLES(10)) dut2 (
    .clk(clk), .arst_n(arst_n), .i_start(start), .i_pause(pause),
    .i_game_win(win), .i_game_lose(lose), .i_ready(ready),
    .o_regenerate(regen), .o_game_running(running), .o_show_banner(banner),
    .o_image_number(img), .o_rating(rating),
    .i_h_coord(pix2.h_coord), .i_v_coord(pix2.v_coord), .i_disp_enbl(pix2.disp_enbl),
    .o_local_x(pix2.local_x), .o_local_y(pix2.local_y), .o_channel(pix2.channel),
    .i_game_rgb({12'h5A5, 12'h0F0}), .i_banner_rgb(12'hABC),
    .o_red(red), .o_green(green), .o_blue(blue)
  );

  // 4-channel hub
  logic       start4 = 0;
  logic       regen4, running4, banner4;
  logic [1:0] img4;
  logic [7:0] rating4;
  logic [3:0] red4, green4, blue4;
  multi_game_hub_if #(.NUM_GAMES(4)) pix4 ();

  multi_game_hub #(.NUM_GAMES(4), .WIN_MASK(4'b0001), .COUNTDOWN_CYCLES(10)) dut4 (
    .clk(clk), .arst_n(arst_n), .i_start(start4), .i_pause(1'b0),
    .i_game_win(4'b0000), .i_game_lose(4'b0000), .i_ready(4'b1111),
    .o_regenerate(regen4), .o_game_running(running4), .o_show_banner(banner4),
    .o_image_number(img4), .o_rating(rating4),
    .i_h_coord(pix4.h_coord), .i_v_coord(pix4.v_coord), .i_disp_enbl(pix4.disp_enbl),
    .o_local_x(pix4.local_x), .o_local_y(pix4.local_y), .o_channel(pix4.channel),
    .i_game_rgb({12'h444, 12'h333, 12'h222, 12'h111}), .i_banner_rgb(12'hDEF),
    .o_red(red4), .o_green(green4), .o_blue(blue4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !running; i++) tick();
    tests++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL start_round_timeout: running=%b required 1", running);
    end
  endtask

  task automatic test_reset();
    pix2.h_coord = 0; pix2.v_coord = 0; pix2.disp_enbl = 0;
    pix4.h_coord = 0; pix4.v_coord = 0; pix4.disp_enbl = 0;
    #12;
    tests++;
    if ({regen, running, banner, img, rating} !== {1'b0, 1'b0, 1'b1, 2'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_outputs: regen=%b run=%b banner=%b img=%0d rating=%0d required 0 0 1 0 0",
               regen, running, banner, img, rating);
    end
    tests++;
    if ({red, green, blue} !== 12'h000) begin
      fails++;
      $display("FAIL reset_rgb: got %h required 000", {red, green, blue});
    end
    tick();
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_session_start();
    start = 1'b1;
    tick();
    tests++;
    if ({regen, banner} !== 2'b11) begin
      fails++;
      $display("FAIL regen_pulse: regen=%b banner=%b required 1 1", regen, banner);
    end
    start = 1'b0;
    tick();
    tests++;
    if (regen !== 1'b0) begin
      fails++;
      $display("FAIL regen_one_cycle: regen=%b required 0", regen);
    end
    tick();
    tests++;
    if ({banner, running} !== 2'b00) begin
      fails++;
      $display("FAIL count_entry: banner=%b run=%b required 0 0", banner, running);
    end
    repeat (9) tick();
    tests++;
    if (running !== 1'b0) begin
      fails++;
      $display("FAIL count_early: run=%b required 0", running);
    end
    tick();
    tests++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL count_done: run=%b required 1", running);
    end
  endtask

  task automatic test_win();
    win = 2'b01;
    tick();
    win = 2'b00;
    tests++;
    if ({img, rating, running, banner} !== {2'd2, 8'd1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL win: img=%0d rating=%0d run=%b banner=%b required 2 1 0 1",
               img, rating, running, banner);
    end
    start_round();
    win = 2'b10;
    tick();
    win = 2'b00;
    tests++;
    if ({running, rating} !== {1'b1, 8'd1}) begin
      fails++;
      $display("FAIL win_masked: run=%b rating=%0d required 1 1", running, rating);
    end
  endtask

  task automatic test_simultaneous();
    win = 2'b01;
    lose = 2'b10;
    tick();
    win = 2'b00;
    lose = 2'b00;
    tests++;
    if ({img, rating} !== {2'd3, 8'd0}) begin
      fails++;
      $display("FAIL lose_priority: img=%0d rating=%0d required 3 0", img, rating);
    end
    for (int r = 0; r < 255; r++) begin
      start_round();
      win = 2'b01;
      tick();
      win = 2'b00;
    end
    tests++;
    if (rating !== 8'hFF) begin
      fails++;
      $display("FAIL rating_count: got %h required ff", rating);
    end
    start_round();
    win = 2'b01;
    tick();
    win = 2'b00;
    tests++;
    if ({rating, img} !== {8'hFF, 2'd2}) begin
      fails++;
      $display("FAIL rating_saturate: rating=%h img=%0d required ff 2", rating, img);
    end
  endtask

  task automatic test_pause();
    start_round();
    pause = 1'b1;
    tick();
    tests++;
    if ({img, banner, running} !== {2'd1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL pause_enter: img=%0d banner=%b run=%b required 1 1 0", img, banner, running);
    end
    lose = 2'b01;
    tick();
    tests++;
    if ({img, rating, running} !== {2'd1, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL pause_ignore_lose: img=%0d rating=%h run=%b required 1 ff 0", img, rating, running);
    end
    lose = 2'b00;
    pause = 1'b0;
    tick();
    tests++;
    if ({running, banner} !== 2'b10) begin
      fails++;
      $display("FAIL pause_resume: run=%b banner=%b required 1 0", running, banner);
    end
    lose = 2'b01;
    tick();
    lose = 2'b00;
    tests++;
    if ({img, rating} !== {2'd3, 8'd0}) begin
      fails++;
      $display("FAIL lose_after_resume: img=%0d rating=%0d required 3 0", img, rating);
    end
  endtask

  task automatic test_slicing();
    pix2.h_coord = 11'd10; pix2.disp_enbl = 1'b1;
    tick();
    tests++;
    if ({red, green, blue} !== 12'hABC) begin
      fails++;
      $display("FAIL banner_rgb: got %h required abc", {red, green, blue});
    end
    pix2.disp_enbl = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 100 && !running4; i++) tick();
    tests++;
    if (running4 !== 1'b1) begin
      fails++;
      $display("FAIL dut4_start_timeout: running=%b required 1", running4);
    end
    pix4.h_coord = 11'd199; pix4.v_coord = 10'd5; pix4.disp_enbl = 1'b1;
    #1;
    tests++;
    if ({pix4.channel, pix4.local_x, pix4.local_y} !== {2'd0, 8'd199, 10'd5}) begin
      fails++;
      $display("FAIL slice_h199: ch=%0d x=%0d y=%0d required 0 199 5",
               pix4.channel, pix4.local_x, pix4.local_y);
    end
    tick();
    tests++;
    if ({red4, green4, blue4} !== 12'h111) begin
      fails++;
      $display("FAIL rgb_ch0: got %h required 111", {red4, green4, blue4});
    end
    pix4.h_coord = 11'd200;
    #1;
    tests++;
    if ({pix4.channel, pix4.local_x, red4, green4, blue4} !== {2'd1, 8'd0, 12'h111}) begin
      fails++;
      $display("FAIL slice_h200: ch=%0d x=%0d rgb=%h required 1 0 111",
               pix4.channel, pix4.local_x, {red4, green4, blue4});
    end
    tick();
    tests++;
    if ({red4, green4, blue4} !== 12'h222) begin
      fails++;
      $display("FAIL rgb_ch1: got %h required 222", {red4, green4, blue4});
    end
    pix4.h_coord = 11'd799;
    #1;
    tests++;
    if ({pix4.channel, pix4.local_x} !== {2'd3, 8'd199}) begin
      fails++;
      $display("FAIL slice_h799: ch=%0d x=%0d required 3 199", pix4.channel, pix4.local_x);
    end
    tick();
    tests++;
    if ({red4, green4, blue4} !== 12'h444) begin
      fails++;
      $display("FAIL rgb_ch3: got %h required 444", {red4, green4, blue4});
    end
    pix4.h_coord = 11'd900;
    pix4.disp_enbl = 1'b0;
    #1;
    tests++;
    if (pix4.channel !== 2'd3) begin
      fails++;
      $display("FAIL slice_offscreen: ch=%0d required 3", pix4.channel);
    end
    tick();
    tests++;
    if ({red4, green4, blue4} !== 12'h000) begin
      fails++;
      $display("FAIL rgb_blank: got %h required 000", {red4, green4, blue4});
    end
  endtask

  task automatic test_reset_mid_regen();
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 2'b00;
    tick();
    tick();
    tests++;
    if ({banner, regen, img} !== {1'b1, 1'b0, 2'd3}) begin
      fails++;
      $display("FAIL regen_wait: banner=%b regen=%b img=%0d required 1 0 3", banner, regen, img);
    end
    arst_n = 1'b0;
    #1;
    tests++;
    if ({regen, running, banner, img, rating} !== {1'b0, 1'b0, 1'b1, 2'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_mid_regen: regen=%b run=%b banner=%b img=%0d rating=%0d required 0 0 1 0 0",
               regen, running, banner, img, rating);
    end
    tick();
    arst_n = 1'b1;
    ready = 2'b11;
    tick();
    start = 1'b1;
    for (int i = 0; i < 100 && !running; i++) tick();
    lose = 2'b01;
    tick();
    lose = 2'b00;
    repeat (3) tick();
    tests++;
    if ({regen, img, banner} !== {1'b0, 2'd3, 1'b1}) begin
      fails++;
      $display("FAIL held_start: regen=%b img=%0d banner=%b required 0 3 1", regen, img, banner);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (regen !== 1'b1) begin
      fails++;
      $display("FAIL repress_start: regen=%b required 1", regen);
    end
  endtask

  initial begin
    test_reset();
    test_session_start();
    test_win();
    test_simultaneous();
    test_pause();
    test_slicing();
    test_reset_mid_regen();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_game_hub.md
Name: multi_game_hub

Overview:
- Parametrised successor to the two-game console top: hosts NUM_GAMES side-by-side game channels on one VGA screen.
- Owns the shared session FSM: start, regenerate, countdown, run, pause, win and lose.
- Owns rating bookkeeping and banner selection.
- Owns screen slicing and local-coordinate generation, plus a registered pixel compositor.
- Sits between the per-game engine/graphics pairs and the VGA output stage.

Parameters:
- NUM_GAMES, 2, number of game channels; equal vertical slices, left to right.
- SCREEN_WIDTH, 800, visible width in pixels; must be divisible by NUM_GAMES.
- SCREEN_HEIGHT, 600, visible height in pixels.
- RATING_WIDTH, 8, width of the rating counter.
- NUM_IMAGES, 4, number of banner images; must be ≥4.
- WIN_MASK, 'b01, NUM_GAMES-bit mask of channels whose win ends a round.
- COUNTDOWN_CYCLES, 25_000_000, length of the pre-round countdown in clock cycles.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- i_start  in  1  start button, level; rising edge used
- i_pause  in  1  pause switch, level
- i_game_win  in  NUM_GAMES  per-channel win
- i_game_lose  in  NUM_GAMES  per-channel lose
- i_ready  in  NUM_GAMES  per-channel level-regeneration done
- o_regenerate  out  1  one-cycle regenerate pulse to all channels
- o_game_running  out  1  high only in RUN
- o_show_banner  out  1  banner replaces game pixels
- o_image_number  out  $clog2(NUM_IMAGES)  banner select
- o_rating  out  RATING_WIDTH  current rating
- i_h_coord  in  11  VGA horizontal coordinate
- i_v_coord  in  10  VGA vertical coordinate
- i_disp_enbl  in  1  VGA display enable
- o_local_x  out  $clog2(SCREEN_WIDTH/NUM_GAMES)  x within current slice
- o_local_y  out  $clog2(SCREEN_HEIGHT)  y (pass-through)
- o_channel  out  $clog2(NUM_GAMES) (min 1)  slice index of current pixel
- i_game_rgb  in  12*NUM_GAMES  per-channel {r,g,b}, combinational from local coords
- i_banner_rgb  in  12  banner pixel
- o_red / o_green / o_blue  out  4 each  registered VGA colour

Behaviour:
- Reset state:
  - FSM in IDLE; o_rating=0, o_regenerate=0, o_game_running=0, o_show_banner=1, o_image_number=0.
  - RGB outputs 0; start edge register 0; countdown counter 0.
- Start edge: rising edge of i_start via a registered previous value. Level-held start does not retrigger.
- IDLE: banner 0. Start edge -> REGEN.
- REGEN:
  - o_regenerate is high on the entry cycle only.
  - Stays until &i_ready, sampled from the cycle after the pulse; then -> COUNT.
  - o_show_banner=1, image unchanged.
- COUNT:
  - Counter runs 0..COUNTDOWN_CYCLES-1; at terminal count -> RUN.
  - o_show_banner=0 (games visible), o_game_running=0.
- RUN: o_game_running=1, o_show_banner=0. Priority order on the same cycle:
  1. Any i_game_lose -> LOST; o_rating cleared to 0.
  2. Else any (i_game_win & WIN_MASK) -> WON; o_rating += 1, saturating at all-ones.
  3. Else i_pause=1 -> PAUSED.
- PAUSED: banner 1. i_pause=0 -> RUN (no countdown). Win/lose inputs ignored.
- WON: banner 2. LOST: banner 3. From either, start edge -> REGEN.
- The rating update happens exactly once per round end, in the transition cycle.
- Start edge in REGEN/COUNT/RUN/PAUSED: ignored.
- Slicing (combinational):
  - o_channel = largest k with i_h_coord ≥ k*SLICE_W, where SLICE_W = SCREEN_WIDTH/NUM_GAMES.
  - o_local_x = i_h_coord - o_channel*SLICE_W; constant compare chain, no divider.
  - Outside the visible area, o_channel = NUM_GAMES-1.
- Compositor:
  - Source: i_banner_rgb if o_show_banner, else i_game_rgb slice o_channel.
  - Forced to 0 when i_disp_enbl=0.
  - Registered: one clock of latency from coordinates to RGB.

Optional Feature:
- Macro: MULTI_GAME_HUB_ROUND_TIMER_EN.
- With the macro defined:
  - Adds parameter ROUND_CYCLES (default 1_500_000_000) and output o_time_left, 16 bits, in seconds (one tick per 25_000_000 cycles).
  - The round timer reloads on COUNT->RUN, decrements only in RUN, and freezes in PAUSED.
  - Expiry in RUN acts as a lose (LOST, rating 0), at lose priority.
  - o_time_left reset value is 0.
- Without the macro: no timer logic, no port; rounds are unbounded.

Decomposition:
- Package multi_game_hub_pkg holds:
  - state enum (IDLE, REGEN, COUNT, RUN, PAUSED, WON, LOST);
  - image index constants IMG_START=0, IMG_PAUSE=1, IMG_WIN=2, IMG_LOSE=3;
  - rgb12_t typedef.
- Sub-module screen_slicer: the combinational channel/local_x generation, parametrised by NUM_GAMES and SCREEN_WIDTH.
- The FSM and compositor stay in the top.

Test Plan:
1. Session start: reset then i_start pulse with i_ready=2'b11 -> o_regenerate high for 1 cycle, COUNT, then o_game_running=1 after COUNTDOWN_CYCLES (set to 10).
2. Win path: RUN, i_game_win=2'b01 -> image 2, o_rating 0->1. Then i_game_win=2'b10 in a fresh round with WIN_MASK='b01 -> no state change.
3. Simultaneous events: i_game_win=2'b01 and i_game_lose=2'b10 in the same cycle -> LOST, image 3, rating 0. Rating at 8'hFF plus a win -> stays 8'hFF.
4. Pause: i_pause=1 in RUN -> image 1 and running=0. Lose during pause -> ignored. i_pause=0 -> RUN next cycle.
5. Slicing, NUM_GAMES=4: h=199 -> channel 0, x 199. h=200 -> channel 1, x 0. h=799 -> channel 3, x 199. RGB appears one cycle later; i_disp_enbl=0 -> 0.
6. Reset mid-REGEN with i_ready=0 -> all outputs return to reset values immediately. Held i_start after release -> no new round until released and pressed again.
